// File: rtl/cga_vram_arbiter_pkg.sv
// Shared types for the CGA video SRAM arbiter.
// FSM states, write-buffer entry and default video page.
package cga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CAP
  } state_t;

  localparam logic [3:0] VRAM_PAGE_DEF = 4'b0001;

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } wbuf_t;

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// CPU memory bus between the ISA-side decode and the arbiter.
// Strobes are active low and asynchronous to clk.
interface cga_cpu_if;
  logic        cpu_cs;
  logic [14:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_memr_l;
  logic        cpu_memw_l;
  logic [7:0]  cpu_q;
  logic        cpu_rdy;

  modport master (
    output cpu_cs, cpu_a, cpu_d,
    output cpu_memr_l, cpu_memw_l,
    input  cpu_q, cpu_rdy
  );

  modport slave (
    input  cpu_cs, cpu_a, cpu_d,
    input  cpu_memr_l, cpu_memw_l,
    output cpu_q, cpu_rdy
  );
endinterface

// File: rtl/cga_vram_arbiter_wbuf_fifo.sv
// Posted CPU write buffer: synchronous FIFO of {addr,data}.
// Pushes while full and pops while empty are ignored.
module cga_wbuf_fifo
  import cga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  wbuf_t                    din,
  output wbuf_t                    head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  wbuf_t          mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the video SRAM between CGA fetch and CPU cycles.
// Video owns a slot when vid_slot=1; CPU uses the rest.
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int         WBUF_DEPTH = 4,
  parameter logic [3:0] VRAM_PAGE  = VRAM_PAGE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [18:0] vid_a,
  input  logic        vid_slot,
  output logic [7:0]  vid_d,
  cga_cpu_if.slave    cpu,
  output logic [18:0] sram_a,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_we_l,
  output logic        sram_oe_l
);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  state_t          state;
  logic [1:0]      rs;
  logic [1:0]      ws;
  logic            rp;
  logic            wp;
  logic            rd_req;
  logic            wr_req;
  logic            rd_pend;
  logic [14:0]     rd_a;
  logic            hold;
  wbuf_t           hold_e;
  logic            rdy;
  logic [7:0]      q;
  logic            push;
  logic            pop;
  wbuf_t           wdin;
  wbuf_t           head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   cnt;
  logic            unused_cnt;
  logic            wr_slot;

  // Sync regs reset to "asserted" so a strobe held through
  // reset never produces a falling edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs <= '0;
      ws <= '0;
      rp <= 1'b0;
      wp <= 1'b0;
    end else begin
      rs <= {rs[0], cpu.cpu_memr_l};
      ws <= {ws[0], cpu.cpu_memw_l};
      rp <= rs[1];
      wp <= ws[1];
    end
  end

  assign rd_req = rp && !rs[1] && cpu.cpu_cs;
  assign wr_req = wp && !ws[1] && cpu.cpu_cs;

  assign push = (wr_req && !full) || (hold && !full);
  assign wdin = hold ? hold_e : {cpu.cpu_a, cpu.cpu_d};
  assign wr_slot = (state == WR) && !vid_slot;
  assign pop  = wr_slot;
  assign unused_cnt = ^cnt;

  cga_wbuf_fifo #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (wdin),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdy     <= 1'b1;
      q       <= '0;
      rd_pend <= 1'b0;
      rd_a    <= '0;
      hold    <= 1'b0;
      hold_e  <= '0;
    end else begin
      if (rd_req) begin
        rd_pend <= 1'b1;
        rd_a    <= cpu.cpu_a;
        rdy     <= 1'b0;
      end
      if (wr_req && full) begin
        hold   <= 1'b1;
        hold_e <= {cpu.cpu_a, cpu.cpu_d};
        rdy    <= 1'b0;
      end
      if (hold && !full) begin
        hold <= 1'b0;
        rdy  <= 1'b1;
      end
      // A video slot aborts a half-done read back to address phase
      if (vid_slot) begin
        if (state == RD_CAP) state <= RD_ADDR;
      end else begin
        unique case (state)
          IDLE: begin
            if (rd_pend && empty) state <= RD_ADDR;
            else if (!empty)      state <= WR;
          end
          WR:      state <= IDLE;
          RD_ADDR: state <= RD_CAP;
          RD_CAP: begin
            q       <= sram_din;
            rdy     <= 1'b1;
            rd_pend <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cpu.cpu_q   = q;
  assign cpu.cpu_rdy = rdy;
  assign vid_d       = sram_din;

  always_comb begin
    sram_a = {VRAM_PAGE, rd_a};
    unique case (1'b1)
      vid_slot: sram_a = vid_a;
      wr_slot:  sram_a = {VRAM_PAGE, head.a};
      default:  ;
    endcase
  end

  assign sram_dout = wr_slot ? head.d : 8'h00;
  assign sram_we_l = !wr_slot;
  assign sram_oe_l = wr_slot;
endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Scoreboard bench for cga_vram_arbiter with a byte-array SRAM model
// and a flat memory reference model for CPU-visible contents.
module tb_cga_vram_arbiter;
  import cga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] vid_a = '0;
  logic        vid_slot = 1'b1;
  logic [7:0]  vid_d;
  logic [18:0] sram_a;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic        sram_we_l;
  logic        sram_oe_l;

  cga_cpu_if cpu ();

  cga_vram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vid_a     (vid_a),
    .vid_slot  (vid_slot),
    .vid_d     (vid_d),
    .cpu       (cpu),
    .sram_a    (sram_a),
    .sram_dout (sram_dout),
    .sram_din  (sram_din),
    .sram_we_l (sram_we_l),
    .sram_oe_l (sram_oe_l)
  );

  always #5 clk = ~clk;

  logic [7:0]  sram [0:32767];
  logic [7:0]  model_mem [0:32767];
  logic [26:0] wq [$];
  logic [7:0]  rq [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          vid_mode = 1;
  int          ph = 0;
  bit          rd_active = 0;
  bit          force_en = 0;
  logic [7:0]  force_v = 8'h00;
  logic        prev_rdy = 1'b1;
  bit          pat [5] = '{1, 0, 1, 0, 0};

  assign sram_din = force_en ? force_v : sram[sram_a[14:0]];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // SRAM write model
  always @(posedge clk)
    if (rst_n && sram_we_l === 1'b0) sram[sram_a[14:0]] <= sram_dout;

  // Video slot driver
  initial forever begin
    @(posedge clk);
    #1;
    vid_a = 19'($urandom);
    case (vid_mode)
      0: vid_slot = 1'b0;
      1: vid_slot = 1'b1;
      2: vid_slot = 1'($urandom_range(0, 1));
      default: begin
        vid_slot = pat[ph];
        ph = (ph + 1) % 5;
      end
    endcase
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (vid_slot) begin
        check("vid sram_a", 32'(sram_a), 32'(vid_a));
        check("vid we_l", 32'(sram_we_l), 32'd1);
        check("vid_d", 32'(vid_d), 32'(sram_din));
      end
      if (sram_we_l === 1'b0) begin
        if (wq.size() == 0)
          fail_now($sformatf("unexpected write a=%h d=%h",
                             sram_a, sram_dout));
        else
          check("sram write", 32'({sram_a, sram_dout}),
                32'(wq.pop_front()));
      end
      if (rd_active && !prev_rdy && cpu.cpu_rdy) begin
        if (rq.size() == 0) fail_now("unexpected read return");
        else check("read data", 32'(cpu.cpu_q), 32'(rq.pop_front()));
      end
    end
    prev_rdy = cpu.cpu_rdy;
  end

  task automatic do_write(input logic [14:0] a, input logic [7:0] d,
                          input bit cs, output bit stalled);
    int n;
    stalled = 0;
    cpu.cpu_a = a;
    cpu.cpu_d = d;
    cpu.cpu_cs = cs;
    if (cs) begin
      wq.push_back({VRAM_PAGE_DEF, a, d});
      model_mem[a] = d;
    end
    cpu.cpu_memw_l = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n = 0;
    while (!cpu.cpu_rdy && n < 400) begin
      stalled = 1;
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) fail_now("write rdy timeout");
    cpu.cpu_memw_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cpu.cpu_cs = 1'b0;
  endtask

  task automatic do_read(input logic [14:0] a, input bit cs);
    int n;
    cpu.cpu_a = a;
    cpu.cpu_cs = cs;
    if (cs) begin
      rq.push_back(model_mem[a]);
      rd_active = 1;
    end
    cpu.cpu_memr_l = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (!cs) check("no-cs rdy", 32'(cpu.cpu_rdy), 32'd1);
    n = 0;
    while (!cpu.cpu_rdy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) fail_now("read rdy timeout");
    @(negedge clk);
    #1;
    if (cs) check("read returned", 32'(rq.size()), 32'd0);
    rq.delete();
    rd_active = 0;
    cpu.cpu_memr_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cpu.cpu_cs = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit st;
    for (int i = 0; i < 32768; i++) begin
      sram[i] = 8'(i) ^ 8'hA5 ^ 8'(i >> 8);
      model_mem[i] = sram[i];
    end
    cpu.cpu_cs = 1'b0;
    cpu.cpu_a = '0;
    cpu.cpu_d = '0;
    cpu.cpu_memr_l = 1'b1;
    cpu.cpu_memw_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst cpu_rdy", 32'(cpu.cpu_rdy), 32'd1);
    check("rst cpu_q", 32'(cpu.cpu_q), 32'd0);
    check("rst we_l", 32'(sram_we_l), 32'd1);
    check("rst oe_l", 32'(sram_oe_l), 32'd0);
    check("rst dout", 32'(sram_dout), 32'd0);
    rst_n = 1'b1;

    // video-only traffic
    force_en = 1;
    force_v = 8'hA5;
    repeat (10) begin
      @(negedge clk);
      check("t1 vid_d", 32'(vid_d), 32'hA5);
    end
    force_en = 0;

    // single posted write
    vid_mode = 0;
    do_write(15'h0123, 8'h3C, 1, st);
    check("t2 stall", 32'(st), 32'd0);
    check("t2 drained", 32'(wq.size()), 32'd0);

    // fill the buffer behind video slots
    vid_mode = 1;
    fork
      for (int i = 0; i < 5; i++) begin
        bit s;
        do_write(15'h0200 + 15'(i), 8'(8'h40 + i), 1, s);
        check($sformatf("t3 stall %0d", i), 32'(s), 32'(i == 4));
      end
      begin
        repeat (60) @(posedge clk);
        vid_mode = 0;
      end
    join
    repeat (10) @(posedge clk);
    check("t3 drained", 32'(wq.size()), 32'd0);

    // read-after-write
    do_write(15'h0010, 8'h77, 1, st);
    do_read(15'h0010, 1);
    check("t4 cpu_q", 32'(cpu.cpu_q), 32'h77);

    // reads with alternating video slots
    vid_mode = 3;
    do_read(15'h0055, 1);
    do_read(15'h0123, 1);
    check("t5 cpu_q", 32'(cpu.cpu_q), 32'h3C);

    // random mix
    vid_mode = 2;
    repeat (60) begin
      logic [14:0] a;
      bit cs;
      a = 15'h0100 + 15'($urandom_range(0, 15));
      cs = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), cs, st);
      else do_read(a, cs);
    end
    vid_mode = 0;
    repeat (10) @(posedge clk);
    check("rand drained", 32'(wq.size()), 32'd0);

    // reset with writes still buffered
    do_read(15'h0010, 1);
    vid_mode = 1;
    for (int i = 0; i < 3; i++)
      do_write(15'h7F00 + 15'(i), 8'(8'hE0 + i), 1, st);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cpu.cpu_cs = 1'b1;
    cpu.cpu_memr_l = 1'b0;
    #1;
    check("t6 cpu_rdy", 32'(cpu.cpu_rdy), 32'd1);
    check("t6 cpu_q", 32'(cpu.cpu_q), 32'd0);
    check("t6 we_l", 32'(sram_we_l), 32'd1);
    wq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vid_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    check("t6 held strobe", 32'(cpu.cpu_rdy), 32'd1);
    cpu.cpu_memr_l = 1'b1;
    cpu.cpu_cs = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    do_read(15'h0010, 1);
    check("t6 post read", 32'(cpu.cpu_q), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
